csa_serial_add_ctrl: RTL and testbench
======================================

Name: csa_serial_add_ctrl

Overview:
- Multi-cycle wide adder/subtractor controller.
- Sequences one instance of the team's 4-bit carry-select adder, one nibble per cycle, LSB nibble first.
- Registers the inter-nibble carry and assembles the WIDTH-bit result.
- Sits between a valid/ready operand producer and a valid/ready result consumer. Trades latency for area versus a full-width adder.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of 4 and >= 8.
- NIB (localparam), WIDTH/4, number of nibble cycles per operation.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand request valid
- in_ready  out  1  block can accept operands
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in (add) / borrow-in (sub)
- sub  in  1  0 = A+B+cin; 1 = A-B-cin
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  result
- cout  out  1  carry-out (add) / not-borrow (sub)
- ovf  out  1  signed overflow; present only with CSA_CTRL_OVF_EN

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, nibble counter=0, carry register=0, operand shift registers=0, sum=0, cout=0, out_valid=0, ovf=0.
- in_ready = (state==IDLE), so it reads 1 immediately after reset.
- FSM states: IDLE, RUN, DONE.
- IDLE, on in_valid&&in_ready (acceptance edge T):
  - a_reg<=a; b_reg<=sub?~b:b; carry<=sub?~cin:cin; cnt<=0; state->RUN.
  - If OVF_EN: also capture a[WIDTH-1] and the effective B MSB.
- RUN, each edge:
  - Adder inputs: a_reg[3:0], b_reg[3:0], carry.
  - Result nibble is shifted into the MSB end of the sum register.
  - a_reg/b_reg shift right by 4; carry<=adder cout; cnt<=cnt+1.
  - When cnt==NIB-1: cout<=adder cout; out_valid<=1; state->DONE.
- Latency: out_valid rises after edge T+NIB, e.g. 4 cycles for WIDTH=16.
- In RUN, sum holds partial values. Consumers must not sample it while out_valid=0.
- DONE:
  - sum, cout and ovf are held stable.
  - in_ready=0; in_valid is ignored and operands are not captured.
  - On out_ready=1: out_valid<=0; state->IDLE.
  - Throughput is one operation per NIB+2 cycles minimum. No overlap with the next acceptance.
- out_ready is ignored outside DONE.
- Arithmetic: all values are modulo 2^WIDTH.
  - Sub: cout=1 means no borrow. cin acts as borrow-in.
  - Chaining cout->cin across operations gives multi-precision add/sub.
- Reset mid-operation (rst_n low in RUN or DONE): immediate return to IDLE with all reset values. The in-flight result is discarded.
- Wrap-around: cnt is ceil(log2(NIB)) bits and is cleared on every acceptance. It never wraps within an operation.

Optional Feature:
- Macro: CSA_CTRL_OVF_EN.
- Defined:
  - Port ovf exists.
  - Set when out_valid rises: ovf = (a_msb==beff_msb) && (sum[WIDTH-1]!=a_msb).
  - Held through DONE; cleared on reset only. It is overwritten by the next result.
- Undefined: no ovf port, no MSB capture registers. All other behaviour is identical.

Test Plan (WIDTH=16):
- Add 0x1234+0x4321, cin=0, sub=0 -> sum=0x5555, cout=0; out_valid high exactly 4 cycles after the acceptance edge; in_ready=0 meanwhile.
- Ripple across all nibbles: 0xFFFF+0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0.
- Subtract 0x0005-0x0007, cin=0, sub=1 -> sum=0xFFFE, cout=0 (borrow). Chained cin=1 on 0x0000-0x0000 -> sum=0xFFFF, cout=0.
- Backpressure: out_ready=0 for 5 cycles in DONE with in_valid=1 and new operands -> sum/cout stable, in_ready=0, no capture. out_ready=1 -> IDLE next cycle, then new operands accepted.
- Reset asserted in the 2nd RUN cycle -> out_valid=0, sum=0, cout=0, in_ready=1 immediately. A subsequent 0x0001+0x0001 yields 0x0002.
- With CSA_CTRL_OVF_EN: 0x7FFF+0x0001 -> sum=0x8000, ovf=1; 0x8000-0x0001 (sub) -> sum=0x7FFF, ovf=1, cout=1.

Source files
------------

// File: rtl/csa_serial_add_ctrl.sv
// Nibble-serial WIDTH-bit add/subtract controller around a 4-bit carry-select adder.
// Optional signed-overflow output enabled by defining CSA_CTRL_OVF_EN.
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// RUN   | one nibble per cycle, LSB nibble first
// DONE  | result valid and held until out_ready
module csa_serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CSA_CTRL_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;

  // Carry-select nibble: both carry hypotheses computed, registered carry picks one
  logic [4:0] sel0;
  logic [4:0] sel1;
  logic [4:0] nib_res;

  assign sel0    = {1'b0, a_reg[3:0]} + {1'b0, b_reg[3:0]};
  assign sel1    = {1'b0, a_reg[3:0]} + {1'b0, b_reg[3:0]} + 5'd1;
  assign nib_res = carry ? sel1 : sel0;

  assign in_ready = (state == IDLE);

`ifdef CSA_CTRL_OVF_EN
  logic a_msb;
  logic b_msb;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      carry     <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
`ifdef CSA_CTRL_OVF_EN
      a_msb     <= 1'b0;
      b_msb     <= 1'b0;
      ovf       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Subtraction as A + ~B + ~borrow
            a_reg <= a;
            b_reg <= sub ? ~b : b;
            carry <= sub ? ~cin : cin;
            cnt   <= '0;
            state <= RUN;
`ifdef CSA_CTRL_OVF_EN
            a_msb <= a[WIDTH-1];
            b_msb <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
`endif
          end
        end
        RUN: begin
          sum   <= {nib_res[3:0], sum[WIDTH-1:4]};
          a_reg <= a_reg >> 4;
          b_reg <= b_reg >> 4;
          carry <= nib_res[4];
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            cout      <= nib_res[4];
            out_valid <= 1'b1;
            state     <= DONE;
`ifdef CSA_CTRL_OVF_EN
            ovf       <= (a_msb == b_msb) && (nib_res[3] != a_msb);
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_serial_add_ctrl.sv
// Randomized + directed bench for csa_serial_add_ctrl against an arithmetic reference model.
// Define CSA_CTRL_OVF_EN to also exercise the overflow output.
module tb_csa_serial_add_ctrl;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
`ifdef CSA_CTRL_OVF_EN
  logic         ovf;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  csa_serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef CSA_CTRL_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    else
      pass_cnt++;
  endtask

  // Reference arithmetic: plain integer math on the operands
  function automatic void ref_calc(input logic [W-1:0] oa, input logic [W-1:0] ob,
                                   input logic oc, input logic os,
                                   output logic [W-1:0] rs, output logic rc, output logic ro);
    longint ua, ub, sa, sb, r, sr;
    ua = longint'(oa);
    ub = longint'(ob);
    sa = oa[W-1] ? ua - (longint'(1) << W) : ua;
    sb = ob[W-1] ? ub - (longint'(1) << W) : ub;
    if (!os) begin
      r  = ua + ub + longint'(oc);
      sr = sa + sb + longint'(oc);
      rc = (r >= (longint'(1) << W));
    end else begin
      r  = ua - ub - longint'(oc);
      sr = sa - sb - longint'(oc);
      rc = (r >= 0);
    end
    rs = r[W-1:0];
    ro = (sr >= (longint'(1) << (W-1))) || (sr < -(longint'(1) << (W-1)));
  endfunction

  // Transaction-level model: result appears NIB edges after acceptance, held until out_ready
  int           m_left;
  logic         m_valid;
  logic [W-1:0] m_sum, p_sum, t_sum;
  logic         m_cout, p_cout, t_cout;
  logic         m_ovf, p_ovf, t_ovf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0; m_valid <= 1'b0;
      m_sum <= '0; m_cout <= 1'b0; m_ovf <= 1'b0;
    end else if (m_left != 0) begin
      if (m_left == 1) begin
        m_valid <= 1'b1; m_sum <= p_sum; m_cout <= p_cout; m_ovf <= p_ovf;
      end
      m_left <= m_left - 1;
    end else if (m_valid) begin
      if (out_ready) m_valid <= 1'b0;
    end else if (in_valid) begin
      ref_calc(a, b, cin, sub, t_sum, t_cout, t_ovf);
      p_sum <= t_sum; p_cout <= t_cout; p_ovf <= t_ovf;
      m_left <= NIB;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", in_ready, (m_left == 0) && !m_valid);
      chk("out_valid", out_valid, m_valid);
      if (m_valid) begin
        chk("sum", sum, m_sum);
        chk("cout", cout, m_cout);
`ifdef CSA_CTRL_OVF_EN
        chk("ovf", ovf, m_ovf);
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    chk("ready_timeout", in_ready, 1'b1);
  endtask

  task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic oc,
                       input logic os, input logic [W-1:0] es, input logic ec,
                       input logic eo, input bit release_now);
    wait_ready();
    a = oa; b = ob; cin = oc; sub = os; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; a = W'($urandom); b = W'($urandom);
    chk("busy_ready", in_ready, 1'b0);
    for (int k = 1; k <= NIB; k++) begin
      tick();
      chk("latency", out_valid, (k == NIB));
      if (k < NIB) chk("run_ready", in_ready, 1'b0);
    end
    chk("lit_sum", sum, es);
    chk("lit_cout", cout, ec);
`ifdef CSA_CTRL_OVF_EN
    chk("lit_ovf", ovf, eo);
`else
    if (eo) $display("note: overflow expectation not checked in this build");
`endif
    if (release_now) begin
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("release_valid", out_valid, 1'b0);
      chk("release_ready", in_ready, 1'b1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] hs;
    logic         hc;
    int           n;

    #3;
    chk("rst_sum", sum, '0);
    chk("rst_cout", cout, 1'b0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_ready", in_ready, 1'b1);
    #20 rst_n = 1'b1;
    tick();

    do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b1);
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    do_op(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b1);
    do_op(16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b1);
`ifdef CSA_CTRL_OVF_EN
    do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1);
    do_op(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b1);
`endif

    // Backpressure: DONE ignores new operands while out_ready is low
    do_op(16'hA5A5, 16'h1111, 1'b1, 1'b0, 16'hB6B7, 1'b0, 1'b0, 1'b0);
    hs = sum; hc = cout;
    in_valid = 1'b1; a = 16'h2222; b = 16'h3333; cin = 1'b0; sub = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_sum", sum, 16'hB6B7);
      chk("bp_cout", cout, hc);
      chk("bp_ready", in_ready, 1'b0);
    end
    chk("bp_hold", sum, hs);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_idle", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("bp_accept", in_ready, 1'b0);
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    chk("bp_result", sum, 16'h5555);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset during the second RUN cycle discards the operation
    wait_ready();
    a = 16'h0F0F; b = 16'h0101; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", out_valid, 1'b0);
    chk("mrst_sum", sum, '0);
    chk("mrst_cout", cout, 1'b0);
    chk("mrst_ready", in_ready, 1'b1);
    #3 rst_n = 1'b1;
    tick();
    do_op(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b1);

    // Randomized operations checked by the model every cycle
    for (int i = 0; i < 60; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = W'($urandom);
      case ($urandom_range(0, 7))
        0: ra = 16'hFFFF;
        1: rb = 16'h8000;
        2: ra = 16'h7FFF;
        3: rb = 16'h0000;
        default: ;
      endcase
      repeat ($urandom_range(0, 2)) tick();
      wait_ready();
      a = ra; b = rb; cin = 1'($urandom); sub = 1'($urandom); in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 20) begin
        out_ready = 1'($urandom);
        tick();
        n++;
      end
      out_ready = 1'b0;
      chk("rand_timeout", out_valid, 1'b1);
      repeat ($urandom_range(0, 3)) begin
        in_valid = 1'($urandom); a = W'($urandom); b = W'($urandom);
        tick();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end

    tick();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
